// File: rtl/freq_gate_bcd.sv
// freq_gate_bcd: gated rising-edge counter on clk_x_in with sequential double-dabble BCD conversion
// and a valid/ready result handshake, all in the clk_ref_in domain.
module freq_gate_bcd #(
    parameter int GATE_CYCLES = 1000000,
    parameter int COUNT_W     = 24,
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_ref_in,
    input  logic                rstn_in,
    input  logic                clk_x_in,
    input  logic                enable_in,
    output logic [4*DIGITS-1:0] result_bcd_out,
    output logic                result_valid_out,
    input  logic                result_ready_in,
    output logic                overflow_out,
    output logic                busy_out
);
    localparam int GW = $clog2(GATE_CYCLES) > 0 ? $clog2(GATE_CYCLES) : 1;
    localparam int IW = $clog2(COUNT_W) > 0 ? $clog2(COUNT_W) : 1;

    typedef enum logic [1:0] {IDLE, GATE, CONVERT, PRESENT} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [GW-1:0]          r_gate_cnt;
    logic [COUNT_W-1:0]     r_edge_cnt;
    logic [COUNT_W-1:0]     r_bin;
    logic                   r_ovf;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [IW-1:0]          r_iter;

    logic                   w_edge;
    logic                   w_sat;
    logic [COUNT_W-1:0]     w_cnt_next;
    logic                   w_ovf_next;
    logic [4*DIGITS-1:0]    w_adj;
    logic [4*DIGITS-1:0]    w_shift;

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_sat      = &r_edge_cnt;
    assign w_cnt_next = r_edge_cnt + COUNT_W'(w_edge & ~w_sat);
    assign w_ovf_next = r_ovf | (w_edge & w_sat);

    // Double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g+:4] = r_bcd[4*g+:4] >= 4'd5 ? r_bcd[4*g+:4] + 4'd3 : r_bcd[4*g+:4];
    end
    assign w_shift = {w_adj[4*DIGITS-2:0], r_bin[COUNT_W-1]};

    always_ff @(posedge clk_ref_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state          <= IDLE;
            r_sync           <= '0;
            r_prev           <= 1'b0;
            r_gate_cnt       <= '0;
            r_edge_cnt       <= '0;
            r_bin            <= '0;
            r_ovf            <= 1'b0;
            r_bcd            <= '0;
            r_iter           <= '0;
            result_bcd_out   <= '0;
            result_valid_out <= 1'b0;
            overflow_out     <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_x_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            case (r_state)
                IDLE: if (enable_in) begin
                    r_state    <= GATE;
                    busy_out   <= 1'b1;
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf      <= 1'b0;
                end
                GATE: if (!enable_in) begin
                    r_state  <= IDLE;
                    busy_out <= 1'b0;
                end else if (r_gate_cnt == GW'(GATE_CYCLES - 1)) begin
                    r_state <= CONVERT;
                    r_bin   <= w_cnt_next;
                    r_ovf   <= w_ovf_next;
                    r_bcd   <= '0;
                    r_iter  <= '0;
                end else begin
                    r_gate_cnt <= r_gate_cnt + GW'(1);
                    r_edge_cnt <= w_cnt_next;
                    r_ovf      <= w_ovf_next;
                end
                CONVERT: begin
                    r_bcd  <= w_shift;
                    r_bin  <= {r_bin[COUNT_W-2:0], 1'b0};
                    r_iter <= r_iter + IW'(1);
                    if (r_iter == IW'(COUNT_W - 1)) begin
                        r_state          <= PRESENT;
                        busy_out         <= 1'b0;
                        result_valid_out <= 1'b1;
                        result_bcd_out   <= r_ovf ? {DIGITS{4'h9}} : w_shift;
                        overflow_out     <= r_ovf;
                    end
                end
                PRESENT: if (result_ready_in) begin
                    result_valid_out <= 1'b0;
                    r_state          <= enable_in ? GATE : IDLE;
                    busy_out         <= enable_in;
                    r_gate_cnt       <= '0;
                    r_edge_cnt       <= '0;
                    r_ovf            <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_gate_bcd.sv
// tb_freq_gate_bcd: randomized self-checking bench; expected counts come from counting rising
// transitions in the driven stimulus pattern and converting with decimal arithmetic.
module tb_freq_gate_bcd;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en1 = 1'b0, rdy1 = 1'b1, en2 = 1'b0, rdy2 = 1'b1;
    logic        x_lvl = 1'b0;
    logic        clk_x;
    logic [31:0] bcd1;
    logic [11:0] bcd2;
    logic        v1, v2, o1, o2, b1, b2;
    int          x_per = 0, pcnt = 0;
    int          n_tests = 0, n_fail = 0;
    bit          pat [0:1199];

    always #5 clk = ~clk;
    always @(negedge clk) pcnt <= (x_per > 0) ? (pcnt + 1) % x_per : 0;
    assign clk_x = (x_per > 0) ? (pcnt < x_per / 2) : x_lvl;

    freq_gate_bcd #(.GATE_CYCLES(100)) dut1 (
        .clk_ref_in(clk), .rstn_in(rst_n), .clk_x_in(clk_x), .enable_in(en1),
        .result_bcd_out(bcd1), .result_valid_out(v1), .result_ready_in(rdy1),
        .overflow_out(o1), .busy_out(b1));

    freq_gate_bcd #(.GATE_CYCLES(1000), .COUNT_W(8), .DIGITS(3)) dut2 (
        .clk_ref_in(clk), .rstn_in(rst_n), .clk_x_in(clk_x), .enable_in(en2),
        .result_bcd_out(bcd2), .result_valid_out(v2), .result_ready_in(rdy2),
        .overflow_out(o2), .busy_out(b2));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] to_bcd(input int n);
        logic [31:0] r;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[4*d+:4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    task automatic clear_pat;
        foreach (pat[i]) pat[i] = 1'b0;
    endtask

    task automatic pulses(input int start, input int k);
        for (int j = 0; j < k; j++) pat[start + 2*j] = 1'b1;
    endtask

    // Enables one DUT, plays pat[] one sample per cycle, waits for valid, then completes
    // the handshake with enable low so the DUT returns to IDLE.
    task automatic run_window(input bit d2, input int gate, output logic [31:0] bcd,
                              output logic ovf, output int lat);
        int budget;
        budget = gate + 200;
        lat = -1;
        if (d2) en2 = 1'b1; else en1 = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            x_lvl = (i < 1200) ? pat[i] : 1'b0;
            if ((d2 ? v2 : v1) === 1'b1) begin
                lat = i;
                break;
            end
        end
        bcd = d2 ? {20'b0, bcd2} : bcd1;
        ovf = d2 ? o2 : o1;
        en1 = 1'b0;
        en2 = 1'b0;
        tick();
        x_lvl = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_tests++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", v1); end
        n_tests++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b1); end
        n_tests++; if (bcd1 !== 32'h0) begin n_fail++; $display("FAIL reset_bcd: got %h want 0", bcd1); end
        n_tests++; if (o1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o1); end
        n_tests++;
        if ({v2, b2, o2, bcd2} !== 15'h0) begin
            n_fail++; $display("FAIL reset_dut2: got v%b b%b o%b bcd %h want all 0", v2, b2, o2, bcd2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_periodic;
        logic [31:0] bcd; logic ovf; int lat;
        x_per = 10;
        clear_pat();
        run_window(1'b0, 100, bcd, ovf, lat);
        n_tests++; if (lat != 125) begin n_fail++; $display("FAIL periodic_latency: got %0d want 125", lat); end
        n_tests++;
        if (bcd !== 32'h9 && bcd !== 32'h10 && bcd !== 32'h11) begin
            n_fail++; $display("FAIL periodic_bcd: got %h want 00000010 +-1", bcd);
        end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL periodic_ovf: got %b want 0", ovf); end
        n_tests++;
        if (v1 !== 1'b0 || b1 !== 1'b0 || bcd1 !== bcd) begin
            n_fail++; $display("FAIL periodic_after_hs: got v%b b%b bcd %h want v0 b0 bcd %h", v1, b1, bcd1, bcd);
        end
        x_per = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] cap; int lat, j;
        x_per = 10;
        rdy1 = 1'b0;
        en1 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (v1 === 1'b1) begin lat = i; break; end
        end
        n_tests++; if (lat != 125) begin n_fail++; $display("FAIL bp_latency: got %0d want 125", lat); end
        cap = bcd1;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_tests++;
            if (v1 !== 1'b1 || bcd1 !== cap) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v%b bcd %h want v1 bcd %h", i, v1, bcd1, cap);
            end
        end
        rdy1 = 1'b1;
        tick();
        n_tests++;
        if (v1 !== 1'b0 || b1 !== 1'b1) begin
            n_fail++; $display("FAIL bp_regate: got v%b b%b want v0 b1", v1, b1);
        end
        j = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (v1 === 1'b1) begin j = i; break; end
        end
        n_tests++; if (j != 124) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 124", j); end
        n_tests++;
        if (bcd1 !== 32'h9 && bcd1 !== 32'h10 && bcd1 !== 32'h11) begin
            n_fail++; $display("FAIL bp_second_bcd: got %h want 00000010 +-1", bcd1);
        end
        en1 = 1'b0;
        tick();
        x_per = 0;
    endtask

    task automatic test_overflow;
        logic [31:0] bcd; logic ovf; int lat;
        x_per = 2;
        run_window(1'b1, 1000, bcd, ovf, lat);
        n_tests++; if (lat != 1009) begin n_fail++; $display("FAIL ovf_latency: got %0d want 1009", lat); end
        n_tests++; if (bcd !== 32'h999) begin n_fail++; $display("FAIL ovf_bcd: got %h want 999", bcd); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_tests++;
        if (o2 !== 1'b1 || v2 !== 1'b0) begin
            n_fail++; $display("FAIL ovf_held: got o%b v%b want o1 v0", o2, v2);
        end
        x_per = 0;
    endtask

    task automatic test_saturation_boundary;
        logic [31:0] bcd, exp; logic ovf; int lat;
        for (int k = 255; k <= 256; k++) begin
            clear_pat();
            pulses(8, k);
            run_window(1'b1, 1000, bcd, ovf, lat);
            exp = (k > 255) ? 32'h999 : to_bcd(k);
            n_tests++;
            if (bcd !== exp || ovf !== (k > 255) || lat != 1009) begin
                n_fail++; $display("FAIL sat_%0d: got bcd %h ovf %b lat %0d want bcd %h ovf %b lat 1009",
                                   k, bcd, ovf, lat, exp, k > 255);
            end
        end
    endtask

    task automatic test_level_high;
        logic [31:0] bcd; logic ovf; int lat;
        x_lvl = 1'b1;
        repeat (5) tick();
        clear_pat();
        for (int i = 0; i <= 110; i++) pat[i] = 1'b1;
        run_window(1'b0, 100, bcd, ovf, lat);
        n_tests++;
        if (bcd !== 32'h0 || lat != 125) begin
            n_fail++; $display("FAIL level_high: got bcd %h lat %0d want 00000000 lat 125", bcd, lat);
        end
        repeat (3) tick();
        clear_pat();
        pat[50] = 1'b1;
        pat[51] = 1'b1;
        run_window(1'b0, 100, bcd, ovf, lat);
        n_tests++;
        if (bcd !== 32'h1 || lat != 125) begin
            n_fail++; $display("FAIL single_pulse: got bcd %h lat %0d want 00000001 lat 125", bcd, lat);
        end
    endtask

    task automatic test_abort;
        logic [31:0] bcd; logic ovf; int lat, k; bit seen;
        x_per = 10;
        en1 = 1'b1;
        repeat (51) tick();
        n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", b1); end
        en1 = 1'b0;
        tick();
        n_tests++;
        if (b1 !== 1'b0 || v1 !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got b%b v%b want b0 v0", b1, v1);
        end
        x_per = 0;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (v1 === 1'b1 || b1 === 1'b1) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL abort_quiet: got activity want none"); end
        k = $urandom_range(1, 30);
        clear_pat();
        pulses(20, k);
        run_window(1'b0, 100, bcd, ovf, lat);
        n_tests++;
        if (bcd !== to_bcd(k) || lat != 125) begin
            n_fail++; $display("FAIL abort_fresh: got bcd %h lat %0d want %h lat 125", bcd, lat, to_bcd(k));
        end
    endtask

    task automatic test_random;
        logic [31:0] bcd, exp; logic ovf; int lat, n;
        for (int it = 0; it < 8; it++) begin
            clear_pat();
            for (int i = 8; i <= 92; i++) pat[i] = 1'($urandom % 2);
            n = 0;
            for (int i = 8; i <= 93; i++) if (pat[i] && !pat[i-1]) n++;
            run_window(1'b0, 100, bcd, ovf, lat);
            exp = to_bcd(n);
            n_tests++;
            if (bcd !== exp || ovf !== 1'b0 || lat != 125) begin
                n_fail++; $display("FAIL random1[%0d]: got bcd %h ovf %b lat %0d want %h ovf 0 lat 125",
                                   it, bcd, ovf, lat, exp);
            end
        end
        for (int it = 0; it < 3; it++) begin
            clear_pat();
            for (int i = 8; i <= 960; i++) pat[i] = 1'($urandom % 2);
            n = 0;
            for (int i = 8; i <= 961; i++) if (pat[i] && !pat[i-1]) n++;
            run_window(1'b1, 1000, bcd, ovf, lat);
            exp = (n > 255) ? 32'h999 : to_bcd(n);
            n_tests++;
            if (bcd !== exp || ovf !== (n > 255) || lat != 1009) begin
                n_fail++; $display("FAIL random2[%0d]: got bcd %h ovf %b lat %0d want %h ovf %b lat 1009",
                                   it, bcd, ovf, lat, exp, n > 255);
            end
        end
    endtask

    task automatic test_reset_convert;
        logic [31:0] bcd; logic ovf; int lat;
        clear_pat();
        pulses(10, 7);
        en1 = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            tick();
            x_lvl = pat[i];
        end
        n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL rc_busy: got %b want 1", b1); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({v1, b1, o1, bcd1} !== 35'h0 || {v2, b2, o2, bcd2} !== 15'h0) begin
            n_fail++; $display("FAIL rc_async_clear: got v%b b%b o%b bcd %h dut2 bcd %h o%b want all 0",
                               v1, b1, o1, bcd1, bcd2, o2);
        end
        repeat (3) tick();
        clear_pat();
        pulses(30, 12);
        rst_n = 1'b1;
        run_window(1'b0, 100, bcd, ovf, lat);
        n_tests++;
        if (bcd !== to_bcd(12) || lat != 125) begin
            n_fail++; $display("FAIL rc_after_release: got bcd %h lat %0d want 00000012 lat 125", bcd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_back_to_back();
        test_overflow();
        test_saturation_boundary();
        test_level_high();
        test_abort();
        test_random();
        test_reset_convert();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
